// File: rtl/issue_ctrl_pkg.sv
// Shared opcodes, class and stall encodings, queue entry type and helpers for issue_ctrl.
package issue_ctrl_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [6:0] Lui    = 7'b0110111;
  localparam logic [6:0] Auipc  = 7'b0010111;
  localparam logic [6:0] Jal    = 7'b1101111;
  localparam logic [6:0] Jalr   = 7'b1100111;
  localparam logic [6:0] B_Type = 7'b1100011;
  localparam logic [6:0] L_Type = 7'b0000011;
  localparam logic [6:0] S_Type = 7'b0100011;
  localparam logic [6:0] OtherI = 7'b0010011;
  localparam logic [6:0] Other  = 7'b0110011;

  typedef enum logic [1:0] {
    CLS_RS  = 2'd0,
    CLS_SLB = 2'd1,
    CLS_ROB = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    STALL_NONE  = 2'd0,
    STALL_EMPTY = 2'd1,
    STALL_ROB   = 2'd2,
    STALL_UNIT  = 2'd3
  } stall_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        has_jump;
  } q_entry_t;

  function automatic cls_e classify(input logic [6:0] opcode);
    cls_e cls;
    case (opcode)
      L_Type, S_Type:                               cls = CLS_SLB;
      Lui, Auipc, Jal, Jalr, B_Type, OtherI, Other: cls = CLS_RS;
      default:                                      cls = CLS_ROB;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Fetch-side, issue-side and control signals of issue_ctrl; master drives, slave is the controller.
interface issue_ctrl_if;
  logic        rdy;
  logic        has_misbranch;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_has_jump;
  logic        queue_full;
  logic        rob_avail;
  logic        rs_avail;
  logic        slb_avail;
  logic        can_issue;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_has_jump;
  logic [1:0]  stall_cause;

  modport master (
    output rdy, has_misbranch, in_valid, in_inst, in_pc, in_has_jump,
    output rob_avail, rs_avail, slb_avail,
    input  queue_full, can_issue, inst, pc, out_has_jump, stall_cause
  );

  modport slave (
    input  rdy, has_misbranch, in_valid, in_inst, in_pc, in_has_jump,
    input  rob_avail, rs_avail, slb_avail,
    output queue_full, can_issue, inst, pc, out_has_jump, stall_cause
  );
endinterface

// File: rtl/issue_ctrl_chk.sv
// Protocol checker for issue_ctrl: a push offered while the queue is full is dropped and flagged.
module issue_ctrl_chk #(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned QUEUE_AW    = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              push_req_i,
  input logic [QUEUE_AW:0] count_i
);

  localparam logic [QUEUE_AW:0] FullCount = (QUEUE_AW+1)'(QUEUE_DEPTH);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push_req_i && (count_i == FullCount))
  );

endmodule

// File: rtl/issue_ctrl_inst_queue_fifo.sv
// Circular instruction buffer with head/tail pointers, occupancy count and single-cycle flush.
module inst_queue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned QUEUE_AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  q_entry_t            wdata_i,
  output q_entry_t            head_o,
  output logic [QUEUE_AW:0]   count_o,
  output logic [QUEUE_AW:0]   count_next_o
);

  localparam logic [QUEUE_AW:0]   FullCount = (QUEUE_AW+1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_AW:0]   CntZero   = (QUEUE_AW+1)'(1'b0);
  localparam logic [QUEUE_AW:0]   CntOne    = (QUEUE_AW+1)'(1'b1);
  localparam logic [QUEUE_AW-1:0] PtrZero   = QUEUE_AW'(1'b0);
  localparam logic [QUEUE_AW-1:0] PtrOne    = QUEUE_AW'(1'b1);

  q_entry_t              mem_q [QUEUE_DEPTH];
  logic [QUEUE_AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [QUEUE_AW:0]     count_q, count_d;
  logic                  push_ok_s, pop_ok_s;

  // Next pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    push_ok_s = push_i && (count_q != FullCount);
    pop_ok_s  = pop_i && (count_q != CntZero);
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_i) begin
      head_d  = PtrZero;
      tail_d  = PtrZero;
      count_d = CntZero;
    end else begin
      if (push_ok_s) begin
        tail_d = tail_q + PtrOne;
      end else begin
        tail_d = tail_q;
      end
      if (pop_ok_s) begin
        head_d = head_q + PtrOne;
      end else begin
        head_d = head_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= PtrZero;
      tail_q  <= PtrZero;
      count_q <= CntZero;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign head_o       = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/issue_ctrl.sv
// Instruction queue plus issue scheduler: classifies the head, gates issue on ROB/unit room, handles flush.
// Optional statistics counters are enabled with the ISSUE_CTRL_STATS_EN macro.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned QUEUE_AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  issue_ctrl_if.slave  bus
`ifdef ISSUE_CTRL_STATS_EN
  ,
  output logic [31:0]  issued_cnt,
  output logic [31:0]  rob_stall_cnt,
  output logic [31:0]  unit_stall_cnt
`endif
);

  localparam logic [QUEUE_AW:0] FullCount   = (QUEUE_AW+1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_AW:0] ThreshCount = (QUEUE_AW+1)'(QUEUE_DEPTH - 1);
  localparam logic [QUEUE_AW:0] CntZero     = (QUEUE_AW+1)'(1'b0);

  q_entry_t          wentry_s, head_s;
  logic [QUEUE_AW:0] count_s, count_next_s;
  cls_e              cls_s;
  stall_e            cause_s;
  logic              unit_ok_s, issue_s, push_req_s, push_s;

  state_e            state_q;
  stall_e            cause_q;
  logic              can_issue_q, full_q, jump_q;
  logic [31:0]       inst_q, pc_q;
`ifdef ISSUE_CTRL_STATS_EN
  logic [31:0]       issued_q, rob_stall_q, unit_stall_q;
`endif

  // Head classification, issue gating and stall cause for this cycle.
  always_comb begin
    wentry_s = '{inst: bus.in_inst, pc: bus.in_pc, has_jump: bus.in_has_jump};
    cls_s    = classify(head_s.inst[6:0]);
    case (cls_s)
      CLS_SLB: unit_ok_s = bus.slb_avail;
      CLS_RS:  unit_ok_s = bus.rs_avail;
      default: unit_ok_s = True;
    endcase
    issue_s = bus.rdy && !bus.has_misbranch && (state_q == ST_RUN) &&
              (count_s != CntZero) && bus.rob_avail && unit_ok_s;
    push_req_s = bus.rdy && !bus.has_misbranch && (state_q == ST_RUN) && bus.in_valid;
    push_s     = push_req_s && (count_s != FullCount);
    if (issue_s) begin
      cause_s = STALL_NONE;
    end else if (count_s == CntZero) begin
      cause_s = STALL_EMPTY;
    end else if (!bus.rob_avail) begin
      cause_s = STALL_ROB;
    end else if (!unit_ok_s) begin
      cause_s = STALL_UNIT;
    end else begin
      cause_s = STALL_EMPTY;
    end
  end

  inst_queue_fifo #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .QUEUE_AW    (QUEUE_AW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.has_misbranch),
    .push_i       (push_s),
    .pop_i        (issue_s),
    .wdata_i      (wentry_s),
    .head_o       (head_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  issue_ctrl_chk #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .QUEUE_AW    (QUEUE_AW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (push_req_s),
    .count_i    (count_s)
  );

  // FSM with registered issue outputs; flush wins over rdy, FLUSH lasts one enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      can_issue_q <= 1'b0;
      full_q      <= 1'b0;
      cause_q     <= STALL_EMPTY;
      inst_q      <= 32'h0000_0000;
      pc_q        <= 32'h0000_0000;
      jump_q      <= 1'b0;
`ifdef ISSUE_CTRL_STATS_EN
      issued_q     <= 32'd0;
      rob_stall_q  <= 32'd0;
      unit_stall_q <= 32'd0;
`endif
    end else if (bus.has_misbranch) begin
      state_q     <= ST_FLUSH;
      can_issue_q <= 1'b0;
      full_q      <= 1'b0;
      cause_q     <= STALL_EMPTY;
    end else if (bus.rdy) begin
      case (state_q)
        ST_RUN:   state_q <= ST_RUN;
        ST_FLUSH: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
      can_issue_q <= issue_s;
      full_q      <= (count_next_s >= ThreshCount);
      cause_q     <= cause_s;
      if (issue_s) begin
        inst_q <= head_s.inst;
        pc_q   <= head_s.pc;
        jump_q <= head_s.has_jump;
      end
`ifdef ISSUE_CTRL_STATS_EN
      if (issue_s) issued_q <= sat_inc(issued_q);
      if (cause_s == STALL_ROB) rob_stall_q <= sat_inc(rob_stall_q);
      if (cause_s == STALL_UNIT) unit_stall_q <= sat_inc(unit_stall_q);
`endif
    end else begin
      can_issue_q <= 1'b0;
    end
  end

  assign bus.can_issue    = can_issue_q;
  assign bus.queue_full   = full_q;
  assign bus.stall_cause  = cause_q;
  assign bus.inst         = inst_q;
  assign bus.pc           = pc_q;
  assign bus.out_has_jump = jump_q;
`ifdef ISSUE_CTRL_STATS_EN
  assign issued_cnt     = issued_q;
  assign rob_stall_cnt  = rob_stall_q;
  assign unit_stall_cnt = unit_stall_q;
`endif

endmodule
